// File: rtl/chip8_draw_ctrl_if.sv
// Bundles the CPU request, memory read port and display row-draw signals
// of the CHIP-8 DXYN draw sequencer.
interface chip8_draw_ctrl_if #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DISP_W_LOG2 = 6,
  parameter int unsigned DISP_H_LOG2 = 5
);
  logic                   start;
  logic [7:0]             x_in;
  logic [7:0]             y_in;
  logic [3:0]             n_in;
  logic [ADDR_W-1:0]      i_base;
  logic                   mem_rd;
  logic [ADDR_W-1:0]      mem_addr;
  logic [7:0]             mem_rdata;
  logic                   draw;
  logic [DISP_W_LOG2-1:0] draw_x;
  logic [DISP_H_LOG2-1:0] draw_y;
  logic [3:0]             row_index;
  logic [7:0]             sprite_data;
  logic                   collision_in;
  logic                   busy;
  logic                   done;
  logic                   vf_out;

  modport slave (
    input  start, x_in, y_in, n_in, i_base, mem_rdata, collision_in,
    output mem_rd, mem_addr, draw, draw_x, draw_y, row_index, sprite_data,
           busy, done, vf_out
  );

  modport master (
    output start, x_in, y_in, n_in, i_base, mem_rdata, collision_in,
    input  mem_rd, mem_addr, draw, draw_x, draw_y, row_index, sprite_data,
           busy, done, vf_out
  );
endinterface

// File: rtl/chip8_draw_ctrl.sv
// CHIP-8 DXYN sprite draw sequencer: per row fetch a sprite byte, latch it,
// pulse the display row-draw strobe, and OR the collisions into VF.
module chip8_draw_ctrl #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DISP_W_LOG2 = 6,
  parameter int unsigned DISP_H_LOG2 = 5
) (
  input  logic              clk,
  input  logic              reset,
  chip8_draw_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    DRAW  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [7:0]             x_q, x_d;
  logic [7:0]             y_q, y_d;
  logic [3:0]             n_q, n_d;
  logic [ADDR_W-1:0]      i_q, i_d;
  logic [3:0]             row_q, row_d;
  logic                   vf_q, vf_d;
  logic [7:0]             sprite_q, sprite_d;
  logic [DISP_W_LOG2-1:0] draw_x_q, draw_x_d;
  logic [DISP_H_LOG2-1:0] draw_y_q, draw_y_d;
  logic [3:0]             row_idx_q, row_idx_d;
  logic [7:0]             y_row;

  assign y_row = y_q + {4'b0000, row_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      n_q       <= '0;
      i_q       <= '0;
      row_q     <= '0;
      vf_q      <= 1'b0;
      sprite_q  <= '0;
      draw_x_q  <= '0;
      draw_y_q  <= '0;
      row_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      n_q       <= n_d;
      i_q       <= i_d;
      row_q     <= row_d;
      vf_q      <= vf_d;
      sprite_q  <= sprite_d;
      draw_x_q  <= draw_x_d;
      draw_y_q  <= draw_y_d;
      row_idx_q <= row_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    n_d       = n_q;
    i_d       = i_q;
    row_d     = row_q;
    vf_d      = vf_q;
    sprite_d  = sprite_q;
    draw_x_d  = draw_x_q;
    draw_y_d  = draw_y_q;
    row_idx_d = row_idx_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          x_d     = bus.x_in;
          y_d     = bus.y_in;
          n_d     = bus.n_in;
          i_d     = bus.i_base;
          vf_d    = 1'b0;
          row_d   = '0;
          state_d = (bus.n_in == 4'd0) ? DONE : FETCH;
        end
      end
      FETCH: state_d = LATCH;
      LATCH: begin
        // Row outputs are registered here so they are stable for the whole DRAW cycle.
        sprite_d  = bus.mem_rdata;
        draw_x_d  = x_q[DISP_W_LOG2-1:0];
        draw_y_d  = y_row[DISP_H_LOG2-1:0];
        row_idx_d = row_q;
        state_d   = DRAW;
      end
      DRAW: begin
        vf_d = vf_q | bus.collision_in;
        if (row_q == n_q - 4'd1) begin
          state_d = DONE;
        end else begin
          row_d   = row_q + 4'd1;
          state_d = FETCH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_rd      = (state_q == FETCH);
  assign bus.mem_addr    = i_q + ADDR_W'(row_q);
  assign bus.draw        = (state_q == DRAW);
  assign bus.draw_x      = draw_x_q;
  assign bus.draw_y      = draw_y_q;
  assign bus.row_index   = row_idx_q;
  assign bus.sprite_data = sprite_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.vf_out      = vf_q;

endmodule

// File: tb/tb_chip8_draw_ctrl.sv
// Directed bench for chip8_draw_ctrl with a synchronous-read memory model
// and a collision source keyed by sprite row.
module tb_chip8_draw_ctrl;
  localparam int unsigned AW = 12;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  chip8_draw_ctrl_if #(.ADDR_W(AW), .DISP_W_LOG2(6), .DISP_H_LOG2(5)) bus ();

  chip8_draw_ctrl #(.ADDR_W(AW), .DISP_W_LOG2(6), .DISP_H_LOG2(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0]  mem [4096];
  logic [15:0] cmask;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  assign bus.collision_in = bus.draw & cmask[bus.row_index];

  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " mem_rd"},      32'(bus.mem_rd),      0);
    check({tag, " mem_addr"},    32'(bus.mem_addr),    0);
    check({tag, " draw"},        32'(bus.draw),        0);
    check({tag, " draw_x"},      32'(bus.draw_x),      0);
    check({tag, " draw_y"},      32'(bus.draw_y),      0);
    check({tag, " row_index"},   32'(bus.row_index),   0);
    check({tag, " sprite_data"}, 32'(bus.sprite_data), 0);
    check({tag, " busy"},        32'(bus.busy),        0);
    check({tag, " done"},        32'(bus.done),        0);
    check({tag, " vf_out"},      32'(bus.vf_out),      0);
  endtask

  // Called at a negedge while IDLE; returns at the negedge two cycles after done.
  task automatic run_draw(input string name, input logic [7:0] x, input logic [7:0] y,
                          input logic [3:0] n, input logic [11:0] ib,
                          input logic [15:0] cm, input bit spam);
    int unsigned last, r, p;
    logic vfe, exp_rd, exp_draw;
    logic [11:0] a;
    string t;
    cmask      = cm;
    bus.start  = 1'b1;
    bus.x_in   = x;
    bus.y_in   = y;
    bus.n_in   = n;
    bus.i_base = ib;
    last = 3 * int'(n) + 1;
    vfe  = 1'b0;
    for (int unsigned k = 1; k <= last + 2; k++) begin
      @(negedge clk);
      t = $sformatf("%s c%0d", name, k);
      exp_rd = 1'b0;
      exp_draw = 1'b0;
      r = 0;
      if (k < last) begin
        r = (k - 1) / 3;
        p = (k - 1) % 3;
        exp_rd   = (p == 0);
        exp_draw = (p == 2);
      end
      check({t, " mem_rd"}, 32'(bus.mem_rd), 32'(exp_rd));
      check({t, " draw"},   32'(bus.draw),   32'(exp_draw));
      check({t, " done"},   32'(bus.done),   32'(k == last));
      check({t, " busy"},   32'(bus.busy),   32'(k <= last));
      check({t, " vf_out"}, 32'(bus.vf_out), 32'(vfe));
      a = ib + 12'(r);
      if (exp_rd) check({t, " mem_addr"}, 32'(bus.mem_addr), 32'(a));
      if (exp_draw) begin
        check({t, " draw_x"},      32'(bus.draw_x),      32'(x % 64));
        check({t, " draw_y"},      32'(bus.draw_y),      (32'(y) + r) % 32);
        check({t, " row_index"},   32'(bus.row_index),   r);
        check({t, " sprite_data"}, 32'(bus.sprite_data), 32'(mem[a]));
        vfe = vfe | cm[r];
      end
      if (spam && k <= last) begin
        bus.start  = 1'b1;
        bus.x_in   = 8'($urandom);
        bus.y_in   = 8'($urandom);
        bus.n_in   = 4'($urandom);
        bus.i_base = 12'($urandom);
      end else begin
        bus.start = 1'b0;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[12'h050] = 8'hF0;
    cmask        = '0;
    bus.start    = 1'b0;
    bus.x_in     = '0;
    bus.y_in     = '0;
    bus.n_in     = '0;
    bus.i_base   = '0;
    bus.mem_rdata = '0;
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    run_draw("single", 8'd5,  8'd3,  4'd1, 12'h050, 16'h0000, 1'b0);
    run_draw("wrap",   8'd70, 8'd30, 4'd4, 12'hFFE, 16'h0000, 1'b0);
    run_draw("coll",   8'd1,  8'd2,  4'd3, 12'h100, 16'h0002, 1'b0);
    run_draw("n0",     8'd0,  8'd0,  4'd0, 12'h200, 16'hFFFF, 1'b0);
    run_draw("spam",   8'd9,  8'd28, 4'd5, 12'h300, 16'h0005, 1'b1);

    // Abort during the second DRAW of a 5-row sprite.
    cmask      = 16'h0001;
    bus.start  = 1'b1;
    bus.x_in   = 8'd12;
    bus.y_in   = 8'd7;
    bus.n_in   = 4'd5;
    bus.i_base = 12'h400;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    check("abort pre draw", 32'(bus.draw),   1);
    check("abort pre vf",   32'(bus.vf_out), 1);
    reset = 1'b1;
    #1;
    check_all_zero("abort");
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("post abort c%0d done", k), 32'(bus.done), 0);
      check($sformatf("post abort c%0d busy", k), 32'(bus.busy), 0);
    end
    run_draw("fresh", 8'd12, 8'd7, 4'd5, 12'h400, 16'h0010, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
